// File: rtl/mux_numero_scan_if.sv
// mux_numero_scan_if: selector bus (channel values, select/mode controls, display outputs); ch_mask exists only with MUXNUM_MASK_EN
interface mux_numero_scan_if #(
    parameter int WIDTH = 10,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] numeros;
    logic [SELW-1:0]      sel;
    logic                 auto_en;
    logic                 hold;
`ifdef MUXNUM_MASK_EN
    logic [NCH-1:0]       ch_mask;
`endif
    logic [WIDTH-1:0]     numero;
    logic [SELW-1:0]      canal;
    logic                 numero_upd;
`ifdef MUXNUM_MASK_EN
    modport master (output numeros, sel, auto_en, hold, ch_mask, input numero, canal, numero_upd);
    modport slave  (input numeros, sel, auto_en, hold, ch_mask, output numero, canal, numero_upd);
`else
    modport master (output numeros, sel, auto_en, hold, input numero, canal, numero_upd);
    modport slave  (input numeros, sel, auto_en, hold, output numero, canal, numero_upd);
`endif
endinterface

// File: rtl/mux_numero_scan.sv
// mux_numero_scan: registered N-channel numero selector, manual select or timed auto-scan; MUXNUM_MASK_EN adds a per-channel scan mask
module mux_numero_scan #(
    parameter int WIDTH = 10,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 50000000,
    parameter int CNTW  = 26
) (
    input logic clk,
    input logic rst_n,
    mux_numero_scan_if.slave bus
);
    typedef enum logic {MANUAL, AUTO} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt, cnt_next;
    logic [SELW-1:0]  canal, canal_next, sel_c, step_ch;
    logic [WIDTH-1:0] numero;
    logic             upd, step, in_auto;
    logic [WIDTH-1:0] chan [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign chan[k] = bus.numeros[k*WIDTH +: WIDTH];
    end

    // wrap by explicit compare so non-power-of-two NCH never overflows into unused indices
    function automatic logic [SELW-1:0] inc(input logic [SELW-1:0] c);
        return (c >= SELW'(NCH-1)) ? '0 : c + 1'b1;
    endfunction

`ifdef MUXNUM_MASK_EN
    logic [SELW-1:0] cand;
    logic            found;
    always_comb begin
        step_ch = canal;
        cand    = canal;
        found   = 1'b0;
        for (int i = 1; i < NCH; i++) begin
            cand = inc(cand);
            if (!found && bus.ch_mask[cand]) begin
                step_ch = cand;
                found   = 1'b1;
            end
        end
    end
`else
    always_comb step_ch = inc(canal);
`endif

    always_comb begin
        in_auto    = bus.auto_en && state == AUTO;
        step       = in_auto && cnt == CNTW'(DWELL-1);
        sel_c      = (bus.sel > SELW'(NCH-1)) ? SELW'(NCH-1) : bus.sel;
        cnt_next   = (!in_auto || step) ? '0 : cnt + 1'b1;
        canal_next = !bus.auto_en ? sel_c : step ? step_ch : canal;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MANUAL;
            cnt    <= '0;
            canal  <= '0;
            numero <= '0;
            upd    <= 1'b0;
        end else begin
            state <= bus.auto_en ? AUTO : MANUAL;
            upd   <= 1'b0;
            if (bus.hold) begin
                if (bus.auto_en && state == MANUAL)
                    cnt <= '0;
            end else begin
                cnt    <= cnt_next;
                canal  <= canal_next;
                numero <= chan[canal_next];
                upd    <= canal_next != canal;
            end
        end
    end

    assign bus.numero     = numero;
    assign bus.canal      = canal;
    assign bus.numero_upd = upd;
endmodule

// File: tb/tb_mux_numero_scan.sv
// tb_mux_numero_scan: directed checks of reset, manual clamp, auto scan, hold and mid-run reset (mask scan with MUXNUM_MASK_EN)
module tb_mux_numero_scan;
    logic clk = 1'b0;
    logic rst_n;
    logic [9:0] ch [3];
    int errs = 0;
    int checks = 0;

    mux_numero_scan_if #(.WIDTH(10), .NCH(3), .SELW(2)) bus ();

    mux_numero_scan #(.WIDTH(10), .NCH(3), .SELW(2), .DWELL(4), .CNTW(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.numeros = {ch[2], ch[1], ch[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int c, input int v, input int u);
        check({tag, ".canal"}, 32'(bus.canal), 32'(c));
        check({tag, ".numero"}, 32'(bus.numero), 32'(v));
        check({tag, ".upd"}, 32'(bus.numero_upd), 32'(u));
    endtask

    function automatic int val(input int c);
        return int'(ch[c]);
    endfunction

    initial begin
        ch[0] = 10'd100; ch[1] = 10'd212; ch[2] = 10'd37;
        rst_n = 1'b0; bus.auto_en = 1'b1; bus.sel = 2'd2; bus.hold = 1'b0;
`ifdef MUXNUM_MASK_EN
        bus.ch_mask = 3'b111;
`endif
        tick(2);
        expect_out("reset", 0, 0, 0);
        rst_n = 1'b1; bus.auto_en = 1'b0; bus.sel = 2'd1;
        tick();
        expect_out("rel", 1, 212, 1);
        tick();
        check("rel_pulse_end", 32'(bus.numero_upd), 0);

        bus.sel = 2'd3;
        tick();
        expect_out("clamp", 2, 37, 1);
        tick();
        ch[2] = 10'd38;
        tick();
        expect_out("data_chg", 2, 38, 0);
        ch[2] = 10'd37;
        tick();
        bus.sel = 2'd0;
        tick();
        expect_out("sel0", 0, 100, 1);

        bus.auto_en = 1'b1;
        tick();
        expect_out("auto_entry", 0, 100, 0);
        for (int s = 0; s < 3; s++) begin
            for (int d = 0; d < 3; d++) begin
                tick();
                expect_out($sformatf("dwell%0d_%0d", s, d), s, val(s), 0);
            end
            tick();
            expect_out($sformatf("step%0d", s), (s + 1) % 3, val((s + 1) % 3), 1);
        end

        tick(2);
        bus.hold = 1'b1;
        ch[0] = 10'd5;
        for (int h = 0; h < 5; h++) begin
            tick();
            expect_out($sformatf("hold%0d", h), 0, 100, 0);
        end
        ch[0] = 10'd100;
        bus.hold = 1'b0;
        tick();
        expect_out("post_hold1", 0, 100, 0);
        tick();
        expect_out("post_hold2", 1, 212, 1);

        tick(4);
        expect_out("to_ch2", 2, 37, 1);
        tick();
        rst_n = 1'b0;
        tick();
        expect_out("mid_reset", 0, 0, 0);
        rst_n = 1'b1; bus.auto_en = 1'b0; bus.sel = 2'd1;
        tick();
        expect_out("manual_after_rst", 1, 212, 1);
        bus.auto_en = 1'b1;
        tick();
        expect_out("entry_ch1", 1, 212, 0);
        tick(3);
        expect_out("entry_ch1_dwell", 1, 212, 0);
        tick();
        expect_out("entry_ch1_step", 2, 37, 1);
        bus.auto_en = 1'b0; bus.sel = 2'd0;
        tick();
        expect_out("leave_auto", 0, 100, 1);

`ifdef MUXNUM_MASK_EN
        bus.ch_mask = 3'b101; bus.auto_en = 1'b1;
        tick();
        expect_out("mask_entry", 0, 100, 0);
        for (int s = 0; s < 3; s++) begin
            tick(3);
            expect_out($sformatf("mask_dwell%0d", s), (s % 2) * 2, val((s % 2) * 2), 0);
            tick();
            expect_out($sformatf("mask_step%0d", s), ((s + 1) % 2) * 2, val(((s + 1) % 2) * 2), 1);
        end
        bus.ch_mask = 3'b000;
        for (int f = 0; f < 8; f++) begin
            tick();
            expect_out($sformatf("mask_none%0d", f), 2, 37, 0);
        end
        ch[2] = 10'd99;
        tick();
        expect_out("mask_none_refresh", 2, 99, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
